// File: rtl/mux_nto1_scan_if.sv
// Channel bus, select controls and registered outputs of the N-to-1 scan multiplexer.
// The master drives the channels and controls; the slave (the mux) drives the outputs.
interface mux_nto1_scan_if #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned SEL_W  = 2
);
   logic [NUM_CH*WIDTH-1:0] i_in_bus;
   logic [SEL_W-1:0]        i_sel;
   logic                    i_mode;
   logic                    i_hold;
   logic [WIDTH-1:0]        o_out;
   logic [SEL_W-1:0]        o_out_ch;
   logic                    o_out_vld;
   logic                    o_ch_chg;

   modport master (
      output i_in_bus, i_sel, i_mode, i_hold,
      input  o_out, o_out_ch, o_out_vld, o_ch_chg
   );

   modport slave (
      input  i_in_bus, i_sel, i_mode, i_hold,
      output o_out, o_out_ch, o_out_vld, o_ch_chg
   );
endinterface

// File: rtl/mux_nto1_scan.sv
// N-to-1 multiplexer with registered output: MANUAL mode follows i_sel,
// SCAN mode steps round-robin through all channels, DWELL cycles per channel.
module mux_nto1_scan #(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned SEL_W  = 2,
   parameter int unsigned DWELL  = 4
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   mux_nto1_scan_if.slave bus
);
   localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [SEL_W-1:0] LastCh = SEL_W'(NUM_CH - 1);
   localparam logic [DW_W-1:0]  LastDw = DW_W'(DWELL - 1);

   typedef enum logic {StManual, StScan} state_e;

   state_e           r_state,   w_state_d;
   logic [SEL_W-1:0] r_ch_cnt,  w_ch_cnt_d;
   logic [DW_W-1:0]  r_dw_cnt,  w_dw_cnt_d;
   logic [WIDTH-1:0] r_out,     w_out_d;
   logic [SEL_W-1:0] r_out_ch,  w_out_ch_d;
   logic             r_out_vld, w_out_vld_d;
   logic             r_ch_chg,  w_ch_chg_d;

   logic [SEL_W-1:0] w_adv_ch;
   logic [DW_W-1:0]  w_adv_dw;

   // Out-of-range indices (NUM_CH not a power of two) yield zero.
   function automatic logic [WIDTH-1:0] pick(input logic [SEL_W-1:0]        idx,
                                             input logic [NUM_CH*WIDTH-1:0] bus_v);
      logic [WIDTH-1:0] res;
      res = '0;
      for (int k = 0; k < int'(NUM_CH); k++) begin
         if (SEL_W'(k) == idx) res = bus_v[k*WIDTH +: WIDTH];
      end
      return res;
   endfunction

   always_comb begin
      w_adv_ch = r_ch_cnt;
      w_adv_dw = r_dw_cnt + DW_W'(1);
      if (r_dw_cnt == LastDw) begin
         w_adv_dw = '0;
         w_adv_ch = (r_ch_cnt == LastCh) ? '0 : r_ch_cnt + SEL_W'(1);
      end
   end

   // Scan counters name the channel currently on o_out, so out loads from the advanced count.
   always_comb begin
      w_state_d   = r_state;
      w_ch_cnt_d  = r_ch_cnt;
      w_dw_cnt_d  = r_dw_cnt;
      w_out_d     = r_out;
      w_out_ch_d  = r_out_ch;
      w_out_vld_d = r_out_vld;
      if (!bus.i_hold) begin
         if (bus.i_mode) begin
            w_state_d   = StScan;
            w_out_vld_d = 1'b1;
            if (r_state == StManual) begin
               w_ch_cnt_d = '0;
               w_dw_cnt_d = '0;
            end else begin
               w_ch_cnt_d = w_adv_ch;
               w_dw_cnt_d = w_adv_dw;
            end
            w_out_d    = pick(w_ch_cnt_d, bus.i_in_bus);
            w_out_ch_d = w_ch_cnt_d;
         end else begin
            w_state_d   = StManual;
            w_out_d     = pick(bus.i_sel, bus.i_in_bus);
            w_out_ch_d  = bus.i_sel;
            w_out_vld_d = (bus.i_sel <= LastCh);
         end
      end
      w_ch_chg_d = (w_out_ch_d != r_out_ch) && !bus.i_hold;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= StManual;
         r_ch_cnt  <= '0;
         r_dw_cnt  <= '0;
         r_out     <= '0;
         r_out_ch  <= '0;
         r_out_vld <= 1'b0;
         r_ch_chg  <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_ch_cnt  <= w_ch_cnt_d;
         r_dw_cnt  <= w_dw_cnt_d;
         r_out     <= w_out_d;
         r_out_ch  <= w_out_ch_d;
         r_out_vld <= w_out_vld_d;
         r_ch_chg  <= w_ch_chg_d;
      end
   end

   assign bus.o_out     = r_out;
   assign bus.o_out_ch  = r_out_ch;
   assign bus.o_out_vld = r_out_vld;
   assign bus.o_ch_chg  = r_ch_chg;
endmodule

// File: tb/tb_mux_nto1_scan.sv
// Scoreboard bench for mux_nto1_scan: a 4-channel and a 3-channel instance,
// directed vectors push expectations, per-instance monitors pop and compare.
module tb_mux_nto1_scan;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux_nto1_scan_if #(.WIDTH(4), .NUM_CH(4), .SEL_W(2)) bus4 ();
   mux_nto1_scan_if #(.WIDTH(4), .NUM_CH(3), .SEL_W(2)) bus3 ();

   mux_nto1_scan #(.WIDTH(4), .NUM_CH(4), .SEL_W(2), .DWELL(4)) u_dut4 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus4.slave)
   );

   mux_nto1_scan #(.WIDTH(4), .NUM_CH(3), .SEL_W(2), .DWELL(4)) u_dut3 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus3.slave)
   );

   typedef struct {
      logic [3:0] out;
      logic [1:0] ch;
      logic       vld;
      logic       chg;
      bit         chk_chg;
   } exp_t;

   exp_t q4[$];
   exp_t q3[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   logic [15:0] drv_bus4 = 16'hDCBA;
   logic [15:0] chan_tbl = 16'hDCBA;

   function automatic logic [3:0] chv(input int c);
      return chan_tbl[c*4 +: 4];
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare(input string tag, input exp_t e, input logic [3:0] out,
                          input logic [1:0] ch, input logic vld, input logic chg);
      check({tag, " out"},     8'(out), 8'(e.out));
      check({tag, " out_ch"},  8'(ch),  8'(e.ch));
      check({tag, " out_vld"}, 8'(vld), 8'(e.vld));
      if (e.chk_chg) check({tag, " ch_chg"}, 8'(chg), 8'(e.chg));
   endtask

   initial forever begin
      exp_t e;
      @(posedge clk);
      #2;
      if (q4.size() > 0) begin
         e = q4.pop_front();
         compare("dut4", e, bus4.o_out, bus4.o_out_ch, bus4.o_out_vld, bus4.o_ch_chg);
      end
   end

   initial forever begin
      exp_t e;
      @(posedge clk);
      #2;
      if (q3.size() > 0) begin
         e = q3.pop_front();
         compare("dut3", e, bus3.o_out, bus3.o_out_ch, bus3.o_out_vld, bus3.o_ch_chg);
      end
   end

   task automatic step4(input logic [1:0] sel, input logic mode, input logic hold,
                        input logic [3:0] eo, input logic [1:0] ec, input logic ev,
                        input logic ecg, input bit cc);
      exp_t e;
      @(negedge clk);
      bus4.i_in_bus = drv_bus4;
      bus4.i_sel    = sel;
      bus4.i_mode   = mode;
      bus4.i_hold   = hold;
      e.out = eo; e.ch = ec; e.vld = ev; e.chg = ecg; e.chk_chg = cc;
      q4.push_back(e);
      @(posedge clk);
   endtask

   task automatic step3(input logic [1:0] sel, input logic mode, input logic hold,
                        input logic [3:0] eo, input logic [1:0] ec, input logic ev,
                        input logic ecg, input bit cc);
      exp_t e;
      @(negedge clk);
      bus3.i_sel  = sel;
      bus3.i_mode = mode;
      bus3.i_hold = hold;
      e.out = eo; e.ch = ec; e.vld = ev; e.chg = ecg; e.chk_chg = cc;
      q3.push_back(e);
      @(posedge clk);
   endtask

   initial begin
      bus4.i_in_bus = drv_bus4;
      bus4.i_sel    = 2'd0;
      bus4.i_mode   = 1'b0;
      bus4.i_hold   = 1'b0;
      bus3.i_in_bus = 12'hCBA;
      bus3.i_sel    = 2'd0;
      bus3.i_mode   = 1'b0;
      bus3.i_hold   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset out",     8'(bus4.o_out),     8'h0);
      check("reset out_vld", 8'(bus4.o_out_vld), 8'h0);
      check("reset ch_chg",  8'(bus4.o_ch_chg),  8'h0);
      rst_n = 1'b1;

      // First manual select after release
      step4(2'd2, 1'b0, 1'b0, 4'hC, 2'd2, 1'b1, 1'b0, 1'b0);

      // Manual sweep
      for (int i = 0; i < 4; i++)
         step4(2'(i), 1'b0, 1'b0, chv(i), 2'(i), 1'b1, 1'b1, 1'b1);

      // Scan: entry edge shows ch0, then dwell of 4 per channel; stop at ch2, dwell index 1
      for (int k = 0; k < 26; k++)
         step4(2'd0, 1'b1, 1'b0, chv((k / 4) % 4), 2'((k / 4) % 4), 1'b1,
               logic'(k % 4 == 0), 1'b1);

      // Hold freezes everything; mode=0 under hold is ignored
      for (int k = 0; k < 5; k++)
         step4(2'd1, logic'(k % 2), 1'b1, 4'hC, 2'd2, 1'b1, 1'b0, 1'b1);
      step4(2'd0, 1'b1, 1'b0, 4'hC, 2'd2, 1'b1, 1'b0, 1'b1);
      step4(2'd0, 1'b1, 1'b0, 4'hC, 2'd2, 1'b1, 1'b0, 1'b1);
      step4(2'd0, 1'b1, 1'b0, 4'hD, 2'd3, 1'b1, 1'b1, 1'b1);

      // Mode switch back to manual, then scan restarts at ch0 with live data on ch0
      step4(2'd1, 1'b0, 1'b0, 4'hB, 2'd1, 1'b1, 1'b1, 1'b1);
      step4(2'd1, 1'b1, 1'b0, 4'hA, 2'd0, 1'b1, 1'b1, 1'b1);
      drv_bus4 = 16'hDCB5;
      step4(2'd1, 1'b1, 1'b0, 4'h5, 2'd0, 1'b1, 1'b0, 1'b1);
      drv_bus4 = 16'hDCBA;
      step4(2'd1, 1'b1, 1'b0, 4'hA, 2'd0, 1'b1, 1'b0, 1'b1);
      step4(2'd1, 1'b1, 1'b0, 4'hA, 2'd0, 1'b1, 1'b0, 1'b1);
      step4(2'd1, 1'b1, 1'b0, 4'hB, 2'd1, 1'b1, 1'b1, 1'b1);
      step4(2'd2, 1'b0, 1'b1, 4'hB, 2'd1, 1'b1, 1'b0, 1'b1);
      step4(2'd2, 1'b0, 1'b1, 4'hB, 2'd1, 1'b1, 1'b0, 1'b1);
      step4(2'd2, 1'b1, 1'b0, 4'hB, 2'd1, 1'b1, 1'b0, 1'b1);

      // Asynchronous reset in mid-cycle, no clock edge needed
      #3;
      check("dut4 queue drained", 8'(q4.size()), 8'h0);
      rst_n = 1'b0;
      #1;
      check("async rst out",     8'(bus4.o_out),     8'h0);
      check("async rst out_ch",  8'(bus4.o_out_ch),  8'h0);
      check("async rst out_vld", 8'(bus4.o_out_vld), 8'h0);
      check("async rst ch_chg",  8'(bus4.o_ch_chg),  8'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step4(2'd2, 1'b0, 1'b0, 4'hC, 2'd2, 1'b1, 1'b0, 1'b0);

      // Three-channel instance: illegal select, then scan wraps 2 -> 0
      step3(2'd3, 1'b0, 1'b0, 4'h0, 2'd3, 1'b0, 1'b1, 1'b1);
      step3(2'd1, 1'b0, 1'b0, 4'hB, 2'd1, 1'b1, 1'b1, 1'b1);
      for (int k = 0; k < 13; k++)
         step3(2'd1, 1'b1, 1'b0, chv((k / 4) % 3), 2'((k / 4) % 3), 1'b1,
               logic'(k % 4 == 0), 1'b1);

      repeat (2) @(posedge clk);
      #3;
      check("dut4 queue empty", 8'(q4.size()), 8'h0);
      check("dut3 queue empty", 8'(q3.size()), 8'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
